// File: rtl/md5_guess_pkg.sv
// Shared widths, alphabet bounds and input-clamping helpers for the MD5 guess engine.
package md5_guess_pkg;

  localparam int unsigned HASH_W          = 128;
  localparam int unsigned CHAR_W          = 8;
  localparam logic [7:0]  CHAR_FIRST      = 8'h61;
  localparam logic [7:0]  CHAR_LAST       = 8'h7A;
  localparam int unsigned MAX_CHARS_LIMIT = 16;

  typedef logic [HASH_W-1:0] word_t;

  typedef enum logic [1:0] {StStartup, StRun, StHalt} run_state_e;

  function automatic logic [CHAR_W-1:0] clamp_char(input logic [CHAR_W-1:0] c);
    return (c < CHAR_FIRST || c > CHAR_LAST) ? CHAR_FIRST : c;
  endfunction

  function automatic logic [2:0] clamp_inc(input logic [2:0] i);
    return (i == 3'd0) ? 3'd1 : i;
  endfunction

endpackage

// File: rtl/md5_guess_engine_guess_odometer.sv
// Character odometer: position 0 steps by a stride and reloads its start, higher
// positions count 'a'..'z'; wrap flags a carry out of the last position.
module guess_odometer
  import md5_guess_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CHAR_W-1:0] start_char,
  input  logic [2:0]        increment,
  input  logic              step,
  output word_t             guess,
  output logic [7:0]        guess_bits,
  output logic              wrap
);

  logic [CHAR_W-1:0] start_q;
  logic [CHAR_W-1:0] chars_q [MAX_CHARS];
  logic [CHAR_W-1:0] chars_d [MAX_CHARS];
  logic [4:0]        len_q, len_d;
  logic [CHAR_W:0]   sum;
  logic              carry;

  always_comb begin
    chars_d = chars_q;
    len_d   = len_q;
    wrap    = 1'b0;
    carry   = 1'b0;
    sum     = {1'b0, chars_q[0]} + (CHAR_W+1)'(increment);
    if (step) begin
      if (sum > {1'b0, CHAR_LAST}) begin
        chars_d[0] = start_q;
        carry      = 1'b1;
      end else begin
        chars_d[0] = sum[CHAR_W-1:0];
      end
      for (int k = 1; k < int'(MAX_CHARS); k++) begin
        if (carry) begin
          if (k >= int'(len_q)) begin
            chars_d[k] = CHAR_FIRST;
            len_d      = len_q + 5'd1;
            carry      = 1'b0;
          end else if (chars_q[k] == CHAR_LAST) begin
            chars_d[k] = CHAR_FIRST;
          end else begin
            chars_d[k] = chars_q[k] + 8'd1;
            carry      = 1'b0;
          end
        end
      end
      // Keyspace finished: freeze on the last guess instead of wrapping around.
      if (carry) begin
        chars_d = chars_q;
        len_d   = len_q;
        wrap    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= start_char;
      for (int k = 0; k < int'(MAX_CHARS); k++) begin
        chars_q[k] <= (k == 0) ? start_char : '0;
      end
      len_q <= 5'd1;
    end else begin
      chars_q <= chars_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    guess = '0;
    for (int k = 0; k < int'(MAX_CHARS); k++) begin
      guess[k*CHAR_W +: CHAR_W] = chars_q[k];
    end
    guess_bits = {len_q, 3'b000};
  end

endmodule

// File: rtl/md5_guess_engine.sv
// Brute-force search core: startup driver, guess odometer and MD5 digest comparator.
// Optional BRUTEFORCE_STATS_EN adds a saturating guess_count output.
module md5_guess_engine
  import md5_guess_pkg::*;
#(
  parameter int unsigned MAX_CHARS      = 16,
  parameter int unsigned STARTUP_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  start_char,
  input  logic [2:0]  increment,
  input  word_t       target_hash,
  input  logic        advance,
  input  word_t       hash_in,
  input  logic        hash_in_valid,
  output logic        enable,
  output word_t       guess,
  output logic [7:0]  guess_bits,
  output logic        guess_valid,
  output logic        equal_valid,
  output logic        hashes_equal,
  output word_t       match_guess,
  output logic        exhausted
`ifdef BRUTEFORCE_STATS_EN
  ,
  output logic [31:0] guess_count
`endif
);

  run_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done, match_now, step, wrap;
  logic        equal_valid_q, hashes_equal_q, exhausted_q;
  word_t       match_guess_q;

  assign done      = hashes_equal_q | exhausted_q;
  assign match_now = hash_in_valid & enable & (hash_in == target_hash);
  // A match in the same cycle as advance wins; the matching guess must stay put.
  assign step      = advance & enable & ~done & ~match_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StStartup;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStartup: begin
        if (cnt_q + 32'd1 >= STARTUP_CYCLES) state_d = StRun;
        else cnt_d = cnt_q + 32'd1;
      end
      StRun:   if (done) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StStartup;
    endcase
  end

  assign enable      = (state_q == StRun);
  assign guess_valid = enable;

  guess_odometer #(
    .MAX_CHARS(MAX_CHARS)
  ) u_odometer (
    .clock      (clock),
    .reset      (reset),
    .start_char (clamp_char(start_char)),
    .increment  (clamp_inc(increment)),
    .step       (step),
    .guess      (guess),
    .guess_bits (guess_bits),
    .wrap       (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      equal_valid_q  <= 1'b0;
      hashes_equal_q <= 1'b0;
      exhausted_q    <= 1'b0;
      match_guess_q  <= '0;
    end else begin
      equal_valid_q <= hash_in_valid & enable;
      if (match_now && !hashes_equal_q) begin
        hashes_equal_q <= 1'b1;
        match_guess_q  <= guess;
      end
      if (wrap) exhausted_q <= 1'b1;
    end
  end

  assign equal_valid  = equal_valid_q;
  assign hashes_equal = hashes_equal_q;
  assign match_guess  = match_guess_q;
  assign exhausted    = exhausted_q;

`ifdef BRUTEFORCE_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else if (step && count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
  end

  assign guess_count = count_q;
`endif

endmodule

// File: tb/tb_md5_guess_engine.sv
// Directed bench for md5_guess_engine: a default instance plus a MAX_CHARS=2 instance.
module tb_md5_guess_engine;
  import md5_guess_pkg::*;

  logic        clock = 1'b0;
  logic        reset, reset2;
  logic [7:0]  start_char, start_char2;
  logic [2:0]  increment, increment2;
  word_t       target_hash, hash_in;
  logic        advance, advance2, hash_in_valid, hash_in_valid2;

  logic        enable, guess_valid, equal_valid, hashes_equal, exhausted;
  word_t       guess, match_guess;
  logic [7:0]  guess_bits;
  logic        enable2, guess_valid2, equal_valid2, hashes_equal2, exhausted2;
  word_t       guess2, match_guess2;
  logic [7:0]  guess_bits2;
`ifdef BRUTEFORCE_STATS_EN
  logic [31:0] guess_count, guess_count2;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  md5_guess_engine dut (
    .clock         (clock),
    .reset         (reset),
    .start_char    (start_char),
    .increment     (increment),
    .target_hash   (target_hash),
    .advance       (advance),
    .hash_in       (hash_in),
    .hash_in_valid (hash_in_valid),
    .enable        (enable),
    .guess         (guess),
    .guess_bits    (guess_bits),
    .guess_valid   (guess_valid),
    .equal_valid   (equal_valid),
    .hashes_equal  (hashes_equal),
    .match_guess   (match_guess),
    .exhausted     (exhausted)
`ifdef BRUTEFORCE_STATS_EN
    ,
    .guess_count   (guess_count)
`endif
  );

  md5_guess_engine #(
    .MAX_CHARS(2)
  ) dut2 (
    .clock         (clock),
    .reset         (reset2),
    .start_char    (start_char2),
    .increment     (increment2),
    .target_hash   (target_hash),
    .advance       (advance2),
    .hash_in       (hash_in),
    .hash_in_valid (hash_in_valid2),
    .enable        (enable2),
    .guess         (guess2),
    .guess_bits    (guess_bits2),
    .guess_valid   (guess_valid2),
    .equal_valid   (equal_valid2),
    .hashes_equal  (hashes_equal2),
    .match_guess   (match_guess2),
    .exhausted     (exhausted2)
`ifdef BRUTEFORCE_STATS_EN
    ,
    .guess_count   (guess_count2)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic adv2();
    advance2 = 1'b1;
    tick();
    advance2 = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    reset2         = 1'b1;
    start_char     = 8'h61;
    start_char2    = 8'h61;
    increment      = 3'd1;
    increment2     = 3'd1;
    target_hash    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    hash_in        = '0;
    hash_in_valid  = 1'b0;
    hash_in_valid2 = 1'b0;
    advance        = 1'b0;
    advance2       = 1'b0;

    // Reset values and startup.
    tick();
    tick();
    check("rst_enable", 128'(enable), 128'd0);
    check("rst_guess", guess, 128'h61);
    check("rst_bits", 128'(guess_bits), 128'd8);
    check("rst_eqv", 128'(equal_valid), 128'd0);
    check("rst_heq", 128'(hashes_equal), 128'd0);
    check("rst_match", match_guess, 128'd0);
    check("rst_exh", 128'(exhausted), 128'd0);
    reset  = 1'b0;
    reset2 = 1'b0;
    tick();
    tick();
    tick();
    check("startup_low", 128'(enable), 128'd0);
    adv();  // ignored: enable still low
    check("startup_rise", 128'(enable), 128'd1);
    check("startup_gvalid", 128'(guess_valid), 128'd1);
    check("startup_guess", guess, 128'h61);

    // Length growth.
    repeat (25) adv();
    check("grow_z", guess, 128'h7A);
    adv();
    check("grow_aa", guess, 128'h6161);
    check("grow_bits", 128'(guess_bits), 128'd16);

    // Stride 3 from 'b'.
    reset      = 1'b1;
    start_char = 8'h62;
    increment  = 3'd3;
    tick();
    reset = 1'b0;
    check("stride_start", guess, 128'h62);
    repeat (4) tick();
    for (int i = 1; i <= 8; i++) begin
      adv();
      check("stride_seq", guess, 128'(8'h62 + 8'(3 * i)));
    end
    adv();
    check("stride_reload", guess, 128'h6162);
    check("stride_bits", 128'(guess_bits), 128'd16);

    // Mismatch then match at "c".
    reset      = 1'b1;
    start_char = 8'h61;
    increment  = 3'd1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    adv();
    adv();
    check("cmp_guess_c", guess, 128'h63);
    hash_in       = target_hash ^ 128'd1;
    hash_in_valid = 1'b1;
    tick();
    hash_in_valid = 1'b0;
    check("mis_eqv", 128'(equal_valid), 128'd1);
    check("mis_heq", 128'(hashes_equal), 128'd0);
    tick();
    check("mis_eqv_pulse", 128'(equal_valid), 128'd0);
    check("mis_enable", 128'(enable), 128'd1);
    hash_in       = target_hash;
    hash_in_valid = 1'b1;
    advance       = 1'b1;
    tick();
    hash_in_valid = 1'b0;
    advance       = 1'b0;
    check("match_eqv", 128'(equal_valid), 128'd1);
    check("match_heq", 128'(hashes_equal), 128'd1);
    check("match_guess", match_guess, 128'h63);
    check("match_no_adv", guess, 128'h63);
    check("match_en_still", 128'(enable), 128'd1);
    tick();
    check("match_en_drop", 128'(enable), 128'd0);
    adv();
    check("match_adv_ign", guess, 128'h63);
    hash_in_valid = 1'b1;
    tick();
    hash_in_valid = 1'b0;
    check("match_noeqv", 128'(equal_valid), 128'd0);
    check("match_sticky", 128'(hashes_equal), 128'd1);

    // Mid-run reset with clamped inputs.
    reset      = 1'b1;
    start_char = 8'h30;
    increment  = 3'd0;
    tick();
    reset = 1'b0;
    check("rr_heq", 128'(hashes_equal), 128'd0);
    check("rr_match", match_guess, 128'd0);
    check("rr_enable", 128'(enable), 128'd0);
    check("rr_guess", guess, 128'h61);
    check("rr_bits", 128'(guess_bits), 128'd8);
    repeat (4) tick();
    adv();
    check("clamp_inc", guess, 128'h62);

    // Exhaustion on the two-character instance: "a" -> "zz" takes 701 advances.
    check("ex_enable", 128'(enable2), 128'd1);
    repeat (701) adv2();
    check("ex_zz", guess2, 128'h7A7A);
    check("ex_not_yet", 128'(exhausted2), 128'd0);
    adv2();
    check("ex_set", 128'(exhausted2), 128'd1);
    check("ex_hold", guess2, 128'h7A7A);
    tick();
    check("ex_en_drop", 128'(enable2), 128'd0);
    adv2();
    check("ex_hold2", guess2, 128'h7A7A);
    reset2      = 1'b1;
    start_char2 = 8'h7B;
    tick();
    reset2 = 1'b0;
    check("ex_rst_exh", 128'(exhausted2), 128'd0);
    check("ex_rst_en", 128'(enable2), 128'd0);
    check("ex_rst_guess", guess2, 128'h61);
    check("ex_rst_bits", 128'(guess_bits2), 128'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md5_guess_engine.md
Name: md5_guess_engine

Overview:
Brute-force password search core for the MD5 cracker. It generates candidate plaintexts, packed right-aligned in 128 bits, over the alphabet 'a'..'z'. It compares externally computed MD5 digests against a target hash and owns the run/stop enable. It integrates three functions: a startup driver, a guess counter, and a hash comparator. It sits between the top-level controller and the external MD5 hashing core.

Parameters:
MAX_CHARS, 16, maximum guess length in characters (1..16).
STARTUP_CYCLES, 4, cycles enable stays low after reset release.

Ports:
clock  in  1  module clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start_char  in  8  first character of position 0 (ASCII).
increment  in  3  step for position 0.
target_hash  in  128  digest being searched for.
advance  in  1  one-cycle request for the next guess.
hash_in  in  128  digest of the current guess from the hashing core.
hash_in_valid  in  1  hash_in is valid this cycle.
enable  out  1  search running.
guess  out  128  current candidate; position 0 in bits [7:0], position k in bits [8k+7:8k]; unused bytes are zero.
guess_bits  out  8  length of the candidate in bits (8*length).
guess_valid  out  1  guess is stable and usable; equals enable.
equal_valid  out  1  one-cycle pulse, comparison result valid.
hashes_equal  out  1  sticky flag, match found.
match_guess  out  128  guess that produced the match.
exhausted  out  1  sticky flag, keyspace finished without a match.

Behaviour:
- Reset values:
  - enable, equal_valid, hashes_equal and exhausted are 0.
  - match_guess is 0.
  - guess = {120'b0, S}, where S is start_char sampled during reset; guess_bits = 8.
  - The startup counter is cleared.
- Input clamping:
  - start_char outside 0x61..0x7A is clamped to 0x61.
  - increment 0 is treated as 1.
- Startup driver:
  - enable rises exactly STARTUP_CYCLES cycles after the first cycle with reset low.
  - enable falls the cycle after hashes_equal or exhausted sets, and stays low until reset.
- Guess counter, position 0:
  - On advance while enable is high, the next guess appears the following cycle.
  - Next value = current + increment. If that exceeds 'z', position 0 reloads S and carries into position 1.
- Guess counter, positions k≥1:
  - A carry increments position k by 1 over 'a'..'z'. Past 'z' it wraps to 'a' and carries on.
  - A carry into an unused position makes it 'a' and increases length by one; guess_bits increases by 8.
  - Carry out of position MAX_CHARS-1: guess is held, exhausted is set, enable drops.
  - Disjoint partitioning across parallel instances comes from distinct start_char values with a common increment.
- Comparator:
  - When hash_in_valid and enable are both high, hash_in is compared with target_hash.
  - One cycle later equal_valid pulses.
  - If the hashes are equal, hashes_equal is set in that same cycle and match_guess captures the guess held when hash_in_valid was sampled.
- Ordering rule: upstream asserts advance only after the hash result for the current guess has been presented.
- Simultaneous events:
  - A matching hash_in_valid together with advance: the match is recorded and the guess is not advanced.
  - advance while enable is low is ignored.
  - hash_in_valid while enable is low produces no equal_valid pulse.
- Reset asserted mid-search restores every reset value on the next edge and re-samples start_char.
- Comparison is a full 128-bit equality; there is no partial match.

Optional Feature:
BRUTEFORCE_STATS_EN
- Defined: adds output guess_count [31:0], the number of accepted advances since reset. It saturates at 0xFFFFFFFF, resets to 0, and freezes when enable is low.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package md5_guess_pkg holds: HASH_W=128, CHAR_W=8, CHAR_FIRST=8'h61, CHAR_LAST=8'h7A, MAX_CHARS_LIMIT=16, and a typedef for the 128-bit guess/hash vector.
- One natural sub-module, guess_odometer: holds the character positions, length and carry chain, and asserts a wrap flag on exhaustion.
- The driver and comparator stay inline in the top.

Test Plan:
1. Startup and first guess:
   - Stimulus: reset 2 cycles, start_char=0x61, increment=1.
   - Required: enable rises 4 cycles after release; guess=0x...61; guess_bits=8.
2. Length growth:
   - Stimulus: 26 advances from 'a'.
   - Required: guess bytes [15:0]=0x6161 ("aa"); guess_bits=16.
3. Stride and partitioning:
   - Stimulus: start_char=0x62, increment=3.
   - Required: position 0 sequence 62,65,68,...,7A, then reload 62 with position 1=61.
4. Match:
   - Stimulus: hash_in=target_hash with hash_in_valid, while guess="c".
   - Required: the next cycle shows equal_valid=1, hashes_equal=1 and match_guess=0x...63; enable low one cycle later; further advances ignored.
5. Mismatch:
   - Stimulus: hash_in differs from target_hash in bit 0.
   - Required: equal_valid pulses, hashes_equal stays 0, enable stays high.
6. Exhaustion and reset:
   - Stimulus: MAX_CHARS=2, advance through "zz".
   - Required: exhausted=1 and enable=0.
   - Then reset mid-run: all outputs return to their reset values.
